mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: IFU and LSU share one memory port, one transaction at a time.
// Contested grants alternate based on the owner of the last completed transaction.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    // Instruction fetch port
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_resp_valid,
    output logic [31:0]             ifu_rdata,
    // Load/store port
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    // Memory port
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    // Status and debug
    output logic                    busy,
    output logic [1:0]              dbgState
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    // Handshake rule: a request transfers on a rising edge where valid and ready are both high;
    // ready is a combinational function of valid and arbiter state and is only offered in IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } stateT;

    stateT                  state;
    stateT                  nextState;
    logic                   lastOwnerLsu;
    logic                   ownerLsu;
    logic [ADDR_WIDTH-1:0]  addrQ;
    logic                   wenQ;
    logic [DATA_WIDTH-1:0]  wdataQ;
    logic [MASK_WIDTH-1:0]  wmaskQ;
    logic                   ifuRespQ;
    logic                   lsuRespQ;
    logic [31:0]            ifuRdataQ;
    logic [DATA_WIDTH-1:0]  lsuRdataQ;

    logic                   grantIfu;
    logic                   grantLsu;
    logic                   respTake;
    logic [31:0]            ifuWord;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState     = state;
        grantIfu      = 1'b0;
        grantLsu      = 1'b0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                // LSU wins a contest unless it also owned the last completed transaction.
                grantLsu      = lsu_req_valid && (!ifu_req_valid || !lastOwnerLsu);
                grantIfu      = ifu_req_valid && !grantLsu;
                ifu_req_ready = grantIfu;
                lsu_req_ready = grantLsu;
                if (grantIfu || grantLsu) begin
                    nextState = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign respTake = (state == WAIT) && mem_resp_valid;
    assign ifuWord  = addrQ[2] ? mem_rdata[63:32] : mem_rdata[31:0];

    // Request fields are captured on accept and held until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ownerLsu <= 1'b0;
            addrQ    <= '0;
            wenQ     <= 1'b0;
            wdataQ   <= '0;
            wmaskQ   <= '0;
        end else if (grantLsu) begin
            ownerLsu <= 1'b1;
            addrQ    <= lsu_addr;
            wenQ     <= lsu_wen;
            wdataQ   <= lsu_wdata;
            wmaskQ   <= lsu_wmask;
        end else if (grantIfu) begin
            ownerLsu <= 1'b0;
            addrQ    <= ifu_addr;
            wenQ     <= 1'b0;
            wdataQ   <= '0;
            wmaskQ   <= '0;
        end
    end

    // Response pulses last one cycle; read data holds until the same requester's next response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastOwnerLsu <= 1'b0;
            ifuRespQ     <= 1'b0;
            lsuRespQ     <= 1'b0;
            ifuRdataQ    <= '0;
            lsuRdataQ    <= '0;
        end else begin
            ifuRespQ <= respTake && !ownerLsu;
            lsuRespQ <= respTake && ownerLsu;
            if (respTake) begin
                lastOwnerLsu <= ownerLsu;
                if (ownerLsu) begin
                    lsuRdataQ <= mem_rdata;
                end else begin
                    ifuRdataQ <= ifuWord;
                end
            end
        end
    end

    assign mem_addr       = addrQ;
    assign mem_wen        = wenQ;
    assign mem_wdata      = wdataQ;
    assign mem_wmask      = wmaskQ;
    assign ifu_resp_valid = ifuRespQ;
    assign lsu_resp_valid = lsuRespQ;
    assign ifu_rdata      = ifuRdataQ;
    assign lsu_rdata      = lsuRdataQ;
    assign busy           = (state != IDLE);
    assign dbgState       = state;

endmodule
